serial_nibble_rx: RTL

Serial receiver that deserialises one UART-style frame: start bit, 4 data bits LSB first, one parity bit, one stop bit.
Presents the nibble and received parity bit in parallel, with a one-cycle valid strobe, to the downstream parity-error checker.
The checker consumes data_out[3:0] as A,B,C,D (A = data_out[3]) and par_out as P.
Parity is not evaluated here; it is forwarded unmodified.

---
 rtl/serial_nibble_rx_pkg.sv | 17 +
 rtl/serial_nibble_rx_sync.sv | 21 ++
 rtl/serial_nibble_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/serial_nibble_rx_pkg.sv
// Shared definitions for the serial nibble receiver: FSM encoding and frame geometry.
package serial_nibble_rx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_PARITY    = 3'd3;
    localparam state_t ST_STOP      = 3'd4;
    localparam state_t ST_WAIT_IDLE = 3'd5;

    localparam int DATA_BITS  = 4;
    // start + data + parity + stop
    localparam int FRAME_BITS = 7;

endpackage

// File: rtl/serial_nibble_rx_sync.sv
// Two-flop synchroniser for an idle-high serial line; both stages reset to 1.
module serial_nibble_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            synced <= 1'b1;
        end else begin
            meta   <= line;
            synced <= meta;
        end
    end

endmodule

// File: rtl/serial_nibble_rx.sv
// Receives start + 4 data bits (LSB first) + parity + stop and presents the nibble
// and raw parity bit with a registered one-cycle strobe.
//
//   state      | meaning
//   IDLE       | waiting for line low
//   START      | half-bit wait, confirm start bit at mid-bit
//   DATA       | sample 4 data bits, one per bit period
//   PARITY     | sample parity bit into holding flop
//   STOP       | sample stop bit, flag good frame or framing error
//   WAIT_IDLE  | after framing error, wait for line to return high
module serial_nibble_rx
    import serial_nibble_rx_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 4,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [3:0] data_out,
    output logic       par_out,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_hold;
    logic                   ok_pend;
    logic                   err_pend;
    logic                   rxs;

    serial_nibble_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line   (rx_in),
        .synced (rxs)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_hold <= 1'b0;
            ok_pend  <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            ok_pend  <= 1'b0;
            err_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == HALF_TC) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == FULL_TC) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rxs;
                        if (bit_idx == LAST_IDX) state <= ST_PARITY;
                        else                     bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt == FULL_TC) begin
                        cnt      <= '0;
                        par_hold <= rxs;
                        state    <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Returning to IDLE mid-stop-bit lets a back-to-back start bit be caught.
                    if (cnt == FULL_TC) begin
                        cnt <= '0;
                        if (rxs) begin
                            ok_pend <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rxs) state <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out    <= 4'b0000;
            par_out     <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= ok_pend;
            frame_err   <= err_pend;
            if (ok_pend) begin
                data_out <= shift;
                par_out  <= par_hold;
            end
        end
    end

endmodule
